// File: rtl/lms_ref_gen.sv
// lms_ref_gen
// Stimulus source for an adaptive LMS FIR datapath in system-identification
// runs. Generates a pseudo-random input stream x from a 16-bit Fibonacci LFSR.
// It also generates the desired response d of a fixed 2-tap "unknown" FIR
// (taps C0, C1). All data is signed Q1.7, and products are scaled by 1/128.
//
// A start pulse begins a burst of N_SAMPLES pairs. One pair is produced on
// each RUN cycle that has ce=1. A stop pulse aborts a running burst.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse, begins a burst from IDLE (ignored elsewhere)
//   stop       aborts a running burst (priority over ce)
//   ce         sample enable while in RUN
//   x_out      input sample to the LMS filter (x_in)
//   d_out      desired sample to the LMS filter (d_in)
//   valid      x_out/d_out were updated this cycle
//   busy       high while in RUN
//   done       one-cycle pulse after the final pair of a burst
//   sample_cnt pairs emitted in the current/last burst
//   state_dbg  FSM state (0=IDLE, 1=RUN, 2=DONE)
//   x1_dbg     second delay tap, carried for LMS alignment checks
//
// Optional feature: define LMS_REF_NOISE_EN to add small noise to d.
// A second LFSR (seed 16'h1D2B) advances in lockstep with the main LFSR.
// Its bits [1:0], read as a signed value -2..1, are added to d before
// saturation.
//
// Output handshake: there is no ready. valid is a one-cycle qualifier,
// asserted the cycle after each ce=1 RUN cycle. While valid is high, x_out
// and d_out hold a new, sample-aligned pair. At all other times they hold
// the last pair produced.
module lms_ref_gen #(
    parameter int                     W1        = 8,
    parameter int                     W2        = 16,
    parameter int                     N_SAMPLES = 1024,
    parameter logic [15:0]            SEED      = 16'hACE1,
    parameter logic signed [W1-1:0]   C0        = 8'sd43,
    parameter logic signed [W1-1:0]   C1        = -8'sd25
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic          ce,
    output logic [W1-1:0] x_out,
    output logic [W1-1:0] d_out,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [15:0]   sample_cnt,
    output logic [1:0]    state_dbg,
    output logic [W1-1:0] x1_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0]          lfsr_q, lfsr_next;
    logic signed [W1-1:0] x0_q, x1_q, x_next;
    logic signed [W2-1:0] prod0, prod1;
    logic signed [W2:0]   sum, shifted, adj;
    logic [W1-1:0]        d_next;
    logic                 load_burst, advance, last_pair;

    assign load_burst = (state_q == S_IDLE) && start;
    assign advance    = (state_q == S_RUN) && !stop && ce;
    assign last_pair  = (sample_cnt == 16'(N_SAMPLES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (stop)                  state_d = S_IDLE;
                else if (ce && last_pair)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_RUN);
    assign state_dbg = state_q;
    assign x1_dbg    = x1_q;

`ifdef LMS_REF_NOISE_EN
    logic [15:0]        nlfsr_q, nlfsr_next;
    logic signed [W2:0] noise;

    assign nlfsr_next = {nlfsr_q[14:0], nlfsr_q[15] ^ nlfsr_q[13] ^ nlfsr_q[12] ^ nlfsr_q[10]};
    assign noise      = (W2+1)'($signed(nlfsr_next[1:0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        nlfsr_q <= 16'h1D2B;
        else if (load_burst) nlfsr_q <= 16'h1D2B;
        else if (advance)    nlfsr_q <= nlfsr_next;
    end
`endif

    // ---------------- datapath ----------------
    always_comb begin
        lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        x_next    = $signed(lfsr_next[W1-1:0]);
        prod0     = W2'(C0) * W2'(x_next);
        prod1     = W2'(C1) * W2'(x0_q);
        sum       = (W2+1)'(prod0) + (W2+1)'(prod1);
        // Arithmetic shift gives Q1.7 rescaling with floor toward -inf.
        shifted   = sum >>> (W1 - 1);
`ifdef LMS_REF_NOISE_EN
        adj       = shifted + noise;
`else
        adj       = shifted;
`endif
        // The value fits in W1 bits only when the bits above the new sign
        // bit all match it. Otherwise clamp to the extreme of the sign.
        if ((adj[W2:W1-1] == '0) || (adj[W2:W1-1] == '1))
            d_next = adj[W1-1:0];
        else if (adj[W2])
            d_next = {1'b1, {(W1-1){1'b0}}};
        else
            d_next = {1'b0, {(W1-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q     <= SEED;
            x0_q       <= '0;
            x1_q       <= '0;
            x_out      <= '0;
            d_out      <= '0;
            valid      <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            valid <= 1'b0;
            // done is registered from DONE, so it follows the last valid by one cycle.
            done  <= (state_q == S_DONE);
            if (load_burst) begin
                lfsr_q     <= SEED;
                x0_q       <= '0;
                x1_q       <= '0;
                sample_cnt <= '0;
            end else if (advance) begin
                lfsr_q     <= lfsr_next;
                x_out      <= x_next;
                d_out      <= d_next;
                x1_q       <= x0_q;
                x0_q       <= x_next;
                valid      <= 1'b1;
                sample_cnt <= sample_cnt + 16'd1;
            end
        end
    end

endmodule
